// File: rtl/quiz_disp_pkg.sv
// Shared constants and types for the quiz display block.
// Contents:
//   NUM_Q, DIGITS  - question count and display digit count
//   GLYPH_*        - active-low seven-segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   bcd_state_e    - score converter state encoding
//   digit_glyph()  - decimal digit 0..9 to glyph (anything else is blank)
package quiz_disp_pkg;

    localparam int unsigned NUM_Q  = 10;
    localparam int unsigned DIGITS = 8;

    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_A     = 8'h88;
    localparam logic [7:0] GLYPH_B     = 8'h83;
    localparam logic [7:0] GLYPH_C     = 8'hC6;
    localparam logic [7:0] GLYPH_D     = 8'hA1;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_N     = 8'hAB;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - accepted only while idle; latches bin and begins conversion
//   bin             - binary value to convert
//   busy            - high whenever the converter is not idle
//   done            - high for the single cycle in which hundreds/tens/ones/value are valid
//   hundreds, tens, ones - BCD result, valid while done is high
//   value           - the binary value that produced the result, valid while done is high
module bin2bcd_seq
    import quiz_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [7:0] value
);

    bcd_state_e  state_q;
    logic [19:0] sr_q;      // {hundreds, tens, ones, binary}
    logic [19:0] sr_adj;
    logic [2:0]  cnt_q;
    logic [7:0]  bin_q;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[11:8] >= 4'd5) begin
            sr_adj[11:8] = sr_q[11:8] + 4'd3;
        end
        if (sr_q[15:12] >= 4'd5) begin
            sr_adj[15:12] = sr_q[15:12] + 4'd3;
        end
        if (sr_q[19:16] >= 4'd5) begin
            sr_adj[19:16] = sr_q[19:16] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        sr_q    <= {12'd0, bin};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_adj << 1;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign hundreds = sr_q[19:16];
    assign tens     = sr_q[15:12];
    assign ones     = sr_q[11:8];
    assign value    = bin_q;

endmodule

// File: rtl/quiz_display_scan.sv
// Quiz display driver: scans an 8-digit multiplexed seven-segment display and the
// "answered" LEDs from the answer-entry controller's state.
// Ports:
//   CLK, RST - clock and synchronous active-high reset
//   Num      - current question number (1..10 valid)
//   Ans      - packed answers, question k in bits [3k-1:3k-3], 0 = unanswered, 1..4 = A..D
//   Point    - binary score
//   End      - quiz submitted; switches the display to "End" plus score
//   Seg      - active-low segments {dp,g,f,e,d,c,b,a}
//   Dig      - active-low one-hot digit enable, Dig[7] leftmost
//   Led      - Led[k-1] set when question k is answered
module quiz_display_scan
    import quiz_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Num,
    input  logic [29:0] Ans,
    input  logic [7:0]  Point,
    input  logic        End,
    output logic [7:0]  Seg,
    output logic [7:0]  Dig,
    output logic [9:0]  Led
);

    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W    = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W   = $clog2(BLINK_DIV);

    // ---------------------------------------------------------------- scan / blink timers
    logic [SCAN_W-1:0]  presc_q;
    logic [2:0]         idx_q;
    logic               scan_tick;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;     // 1 = visible phase
    logic               blink_wrap;

    assign scan_tick  = (presc_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q     <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            presc_q <= scan_tick ? '0 : presc_q + SCAN_W'(1);
            if (scan_tick) begin
                idx_q <= idx_q + 3'd1;
            end
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
            if (blink_wrap) begin
                blink_q <= ~blink_q;
            end
        end
    end

    // ---------------------------------------------------------------- answered count / LEDs
    logic [3:0] ans_cnt_d;
    logic [3:0] ans_cnt_q;
    logic [9:0] led_d;

    always_comb begin
        ans_cnt_d = '0;
        led_d     = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            led_d[k] = |Ans[3*k +: 3];
            if (led_d[k]) begin
                ans_cnt_d = ans_cnt_d + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ans_cnt_q <= '0;
            Led       <= '0;
        end else begin
            ans_cnt_q <= ans_cnt_d;
            Led       <= led_d;
        end
    end

    // ---------------------------------------------------------------- score conversion
    logic       bcd_busy;
    logic       bcd_done;
    logic       bcd_start;
    logic [3:0] bcd_h;
    logic [3:0] bcd_t;
    logic [3:0] bcd_o;
    logic [7:0] bcd_value;
    logic [7:0] last_q;      // score value currently shown
    logic [3:0] score_h_q;
    logic [3:0] score_t_q;
    logic [3:0] score_o_q;

    // A change during a conversion is picked up once the converter is idle again, since
    // last_q then holds the value just converted rather than the live score.
    assign bcd_start = !bcd_busy && (Point != last_q);

    bin2bcd_seq u_bcd (
        .clk      (CLK),
        .rst      (RST),
        .start    (bcd_start),
        .bin      (Point),
        .busy     (bcd_busy),
        .done     (bcd_done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o),
        .value    (bcd_value)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q    <= '0;
            score_h_q <= '0;
            score_t_q <= '0;
            score_o_q <= '0;
        end else if (bcd_done) begin
            last_q    <= bcd_value;
            score_h_q <= bcd_h;
            score_t_q <= bcd_t;
            score_o_q <= bcd_o;
        end
    end

    // ---------------------------------------------------------------- glyph selection
    logic       num_valid;
    logic [2:0] ans_sel;
    logic [3:0] num_tens;
    logic [3:0] num_ones;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic [7:0] ans_glyph;
    logic [7:0] seg_d;
    logic [7:0] dig_d;

    assign num_valid = (Num >= 4'd1) && (Num <= 4'd10);
    assign num_tens  = (Num == 4'd10) ? 4'd1 : 4'd0;
    assign num_ones  = (Num == 4'd10) ? 4'd0 : Num;
    assign cnt_tens  = (ans_cnt_q == 4'd10) ? 4'd1 : 4'd0;
    assign cnt_ones  = (ans_cnt_q == 4'd10) ? 4'd0 : ans_cnt_q;

    always_comb begin
        ans_sel = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            if (Num == 4'(k + 1)) begin
                ans_sel = Ans[3*k +: 3];
            end
        end
    end

    always_comb begin
        ans_glyph = GLYPH_DASH;
        if (num_valid) begin
            case (ans_sel)
                3'd0:    ans_glyph = blink_q ? GLYPH_DASH : GLYPH_BLANK;
                3'd1:    ans_glyph = GLYPH_A;
                3'd2:    ans_glyph = GLYPH_B;
                3'd3:    ans_glyph = GLYPH_C;
                3'd4:    ans_glyph = GLYPH_D;
                default: ans_glyph = GLYPH_DASH;
            endcase
        end
    end

    always_comb begin
        seg_d = GLYPH_BLANK;
        if (End) begin
            case (idx_q)
                3'd7: seg_d = GLYPH_E;
                3'd6: seg_d = GLYPH_N;
                3'd5: seg_d = GLYPH_D;
                3'd2: seg_d = (score_h_q == 4'd0) ? GLYPH_BLANK : digit_glyph(score_h_q);
                3'd1: seg_d = (score_h_q == 4'd0 && score_t_q == 4'd0) ? GLYPH_BLANK
                                                                        : digit_glyph(score_t_q);
                3'd0: seg_d = digit_glyph(score_o_q);
                default: seg_d = GLYPH_BLANK;
            endcase
        end else begin
            case (idx_q)
                3'd7: seg_d = num_valid ? digit_glyph(num_tens) : GLYPH_DASH;
                3'd6: seg_d = num_valid ? digit_glyph(num_ones) : GLYPH_DASH;
                3'd4: seg_d = ans_glyph;
                3'd1: seg_d = digit_glyph(cnt_tens);
                3'd0: seg_d = digit_glyph(cnt_ones);
                default: seg_d = GLYPH_BLANK;
            endcase
        end
    end

    assign dig_d = ~(8'b1 << idx_q);

    // Seg and Dig come from the same index so a digit never shows its neighbour's glyph.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Seg <= 8'hFF;
            Dig <= 8'hFF;
        end else begin
            Seg <= seg_d;
            Dig <= dig_d;
        end
    end

endmodule

// File: tb/tb_quiz_display_scan.sv
// Directed self-checking bench for quiz_display_scan (dwell 10 cycles, blink every 20).
module tb_quiz_display_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  Num;
    logic [29:0] Ans;
    logic [7:0]  Point;
    logic        End;
    logic [7:0]  Seg;
    logic [7:0]  Dig;
    logic [9:0]  Led;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // rising edges since reset release

    quiz_display_scan #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .BLINK_HZ (25)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Num   (Num),
        .Ans   (Ans),
        .Point (Point),
        .End   (End),
        .Seg   (Seg),
        .Dig   (Dig),
        .Led   (Led)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Advance until digit d is enabled; an expired budget is reported as a failure.
    task automatic seek(input int d);
        logic [7:0] want;
        want = ~(8'b1 << d);
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (Dig === want) return;
        end
        check("seek_timeout", {24'd0, Dig}, {24'd0, want});
    endtask

    task automatic seek_seg(input string tag, input int d, input logic [7:0] exp);
        seek(d);
        check(tag, {24'd0, Seg}, {24'd0, exp});
    endtask

    // Blink phase after n edges from reset: starts visible, toggles every 20 edges.
    function automatic logic phase(input int n);
        return ((n / 20) % 2) == 0;
    endfunction

    logic [11:0] exp_bcd;

    initial begin
        End   = 1'b0;
        Num   = 4'd3;
        Ans   = 30'd4 << 6;      // Q3 = D
        Point = 8'd0;

        // 1. reset and scan timing
        step(3);
        check("rst_seg", {24'd0, Seg}, 32'hFF);
        check("rst_dig", {24'd0, Dig}, 32'hFF);
        check("rst_led", {22'd0, Led}, 32'h0);
        RST = 1'b0;
        step(1);
        check("first_dig", {24'd0, Dig}, 32'hFE);
        step(9);
        check("dwell_end", {24'd0, Dig}, 32'hFE);
        step(1);
        check("dig1", {24'd0, Dig}, 32'hFD);
        step(70);
        check("scan_wrap", {24'd0, Dig}, 32'hFE);

        // 2. entry mode, Num=3, Q3=D
        seek_seg("e_d7", 7, 8'hC0);
        seek_seg("e_d6", 6, 8'hB0);
        seek_seg("e_d5", 5, 8'hFF);
        seek_seg("e_d4", 4, 8'hA1);
        seek_seg("e_d1", 1, 8'hC0);
        seek_seg("e_d0", 0, 8'hF9);
        check("led_q3", {22'd0, Led}, 32'h004);

        // 3. unanswered current question blinks
        Num = 4'd5;
        seek(4);
        check("blink_d4", {24'd0, Seg}, phase(cyc - 1) ? 32'hBF : 32'hFF);
        check("blink_ph_a", {31'd0, dut.blink_q}, {31'd0, phase(cyc)});
        step(20);
        check("blink_ph_b", {31'd0, dut.blink_q}, {31'd0, phase(cyc)});
        seek(4);
        check("blink_d4_b", {24'd0, Seg}, phase(cyc - 1) ? 32'hBF : 32'hFF);

        // 4. out-of-range Num, then Num=10 with every question answered
        Num = 4'd12;
        seek_seg("oor_d7", 7, 8'hBF);
        seek_seg("oor_d6", 6, 8'hBF);
        seek_seg("oor_d4", 4, 8'hBF);
        seek_seg("oor_d4b", 4, 8'hBF);
        Num = 4'd10;
        for (int k = 0; k < 9; k++) Ans[3*k +: 3] = 3'd1;
        Ans[29:27] = 3'd3;
        seek_seg("n10_d7", 7, 8'hF9);
        seek_seg("n10_d6", 6, 8'hC0);
        seek_seg("n10_d4", 4, 8'hC6);
        seek_seg("n10_d1", 1, 8'hF9);
        seek_seg("n10_d0", 0, 8'hC0);
        check("led_all", {22'd0, Led}, 32'h3FF);
        Num = 4'd1;
        Ans[2:0] = 3'd6;
        seek_seg("bad_ans", 4, 8'hBF);

        // 5. end mode and score display
        End   = 1'b1;
        Point = 8'd100;
        step(12);
        seek_seg("end_d7", 7, 8'h86);
        seek_seg("end_d6", 6, 8'hAB);
        seek_seg("end_d5", 5, 8'hA1);
        seek_seg("end_d4", 4, 8'hFF);
        seek_seg("end_d3", 3, 8'hFF);
        seek_seg("p100_d2", 2, 8'hF9);
        seek_seg("p100_d1", 1, 8'hC0);
        seek_seg("p100_d0", 0, 8'hC0);
        Point = 8'd50;
        step(9);
        check("bcd_hold", {28'd0, dut.score_h_q}, 32'd1);
        step(1);
        check("bcd_h50", {28'd0, dut.score_h_q}, 32'd0);
        check("bcd_t50", {28'd0, dut.score_t_q}, 32'd5);
        seek_seg("p50_d2", 2, 8'hFF);
        seek_seg("p50_d1", 1, 8'h92);
        seek_seg("p50_d0", 0, 8'hC0);
        Point = 8'd0;
        step(12);
        seek_seg("p0_d2", 2, 8'hFF);
        seek_seg("p0_d1", 1, 8'hFF);
        seek_seg("p0_d0", 0, 8'hC0);

        // 6. score change mid-conversion, then reset mid-conversion
        Point = 8'd90;
        for (int j = 1; j <= 25; j++) begin
            step(1);
            if (j == 3) Point = 8'd70;
            exp_bcd = (j < 10) ? 12'h000 : (j < 20) ? 12'h090 : 12'h070;
            check("bcd_seq", {20'd0, dut.score_h_q, dut.score_t_q, dut.score_o_q},
                  {20'd0, exp_bcd});
        end
        seek_seg("p70_d2", 2, 8'hFF);
        seek_seg("p70_d1", 1, 8'hF8);
        seek_seg("p70_d0", 0, 8'hC0);
        Point = 8'd123;
        step(4);
        RST = 1'b1;
        step(1);
        check("rstmid_busy", {31'd0, dut.u_bcd.busy}, 32'd0);
        check("rstmid_bcd", {20'd0, dut.score_h_q, dut.score_t_q, dut.score_o_q}, 32'h0);
        check("rstmid_seg", {24'd0, Seg}, 32'hFF);
        check("rstmid_dig", {24'd0, Dig}, 32'hFF);
        check("rstmid_led", {22'd0, Led}, 32'h0);
        RST = 1'b0;
        step(1);
        check("rel_dig", {24'd0, Dig}, 32'hFE);
        step(12);
        seek_seg("p123_d2", 2, 8'hF9);
        seek_seg("p123_d1", 1, 8'hA4);
        seek_seg("p123_d0", 0, 8'hB0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
